adc_freq_meter: RTL and testbench
=================================

ADC_FREQ_METER -- requirements
Module: adc_freq_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 50_000_000, sets the gate window length in sys_clk cycles (1 s at 50 MHz).
REQ-002 Parameter HI_TH, default 8'd160, is the upper hysteresis threshold.
REQ-003 Parameter LO_TH, default 8'd96, is the lower hysteresis threshold; LO_TH < HI_TH SHALL hold.
REQ-004 Parameter CNT_W, default 20, is the width of the frequency result.
REQ-005 Port sys_clk, input, 1 bit: the single clock, 50 MHz.
REQ-006 Port sys_rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port adc_clk, output, 1 bit: ADC sample clock, equal to ~sys_clk.
REQ-008 Port adc_data, input, 8 bits: unsigned ADC sample, valid on every sys_clk rising edge.
REQ-009 Port freq_out, output, CNT_W bits: rising crossings counted in the last completed gate (Hz at default GATE_CYCLES).
REQ-010 Port vpp_out, output, 8 bits: max minus min sample over the last completed gate.
REQ-011 Port meas_valid, output, 1 bit: one-cycle pulse when freq_out/vpp_out update.
REQ-012 Port freq_ovf, output, 1 bit: set when the last completed gate saturated the count.

Function
REQ-013 adc_data SHALL be registered once before any processing; all later latencies count from this register.
REQ-014 The comparator FSM SHALL have states INIT, LOW and HIGH.
REQ-015 In INIT: sample >= HI_TH -> HIGH; sample <= LO_TH -> LOW; otherwise stay in INIT; no crossing is counted.
REQ-016 In LOW: sample >= HI_TH -> HIGH with a one-cycle rise strobe; otherwise stay in LOW.
REQ-017 In HIGH: sample <= LO_TH -> LOW with no strobe; otherwise stay in HIGH.
REQ-018 The gate counter SHALL run 0..GATE_CYCLES-1 and wrap; the cycle at GATE_CYCLES-1 is gate_end.
REQ-019 The edge counter SHALL increment on each rise strobe and saturate at 2^CNT_W-1; the saturation sets an internal ovf flag.
REQ-020 On gate_end, the following SHALL register on the next edge, with meas_valid high for exactly that one cycle:
 - freq_out <= edge count including any strobe in the gate_end cycle
 - freq_ovf <= ovf flag
 - vpp_out <= max-min including the gate_end sample
REQ-021 After gate_end, the edge count, ovf flag and max/min SHALL restart for the next window:
 - edge count reloads to 0, or to 1 if a strobe arrives in the first cycle of the new window
 - ovf flag clears
 - max and min reload from the first sample of the new window
REQ-022 The comparator FSM state SHALL persist across gate boundaries.
REQ-023 freq_out, vpp_out and freq_ovf SHALL hold their values between meas_valid pulses.
REQ-024 A constant input that never leaves INIT SHALL give freq_out=0 and the true vpp_out (0 for a constant input).
REQ-025 The first measurement SHALL appear GATE_CYCLES+2 cycles after reset deassertion: 1 input-register stage plus 1 result-register stage.

Reset
REQ-026 With sys_rst high at a clock edge, the block SHALL set:
 - FSM = INIT, gate counter = 0, edge count = 0
 - max = 0, min = 255, ovf flag = 0
 - freq_out = 0, vpp_out = 0, freq_ovf = 0, meas_valid = 0
REQ-027 Reset asserted mid-gate SHALL discard the partial window, and no meas_valid SHALL be produced for it.
REQ-028 adc_clk SHALL be unaffected by reset.

Structure
REQ-029 The FSM state encoding and the default thresholds SHALL live in a shared package dds_pkg.
REQ-030 The hysteresis comparator FSM SHALL be a sub-module adc_hyst_cmp that outputs the rise strobe.
REQ-031 Gating, counting, peak tracking and the result registers SHALL stay in adc_freq_meter.

Verification
(Bench runs GATE_CYCLES=1000.)
REQ-032 Square wave, 0 and 255 alternating every 50 cycles -> freq_out=10, vpp_out=255, freq_ovf=0, meas_valid once per 1000 cycles.
REQ-033 Constant adc_data=128 -> freq_out=0, vpp_out=0, FSM stays in INIT.
REQ-034 Noisy ramp between 100 and 155 (always inside the hysteresis band), then a clean square wave of period 200 -> freq_out=0 for the ramp windows, then 5.
REQ-035 Rise aligned to the gate_end cycle -> counted in the closing window; rise in the first cycle of the new window -> counted in the new window.
REQ-036 CNT_W=3 with period-4 square wave (250 rises per window) -> freq_out=7, freq_ovf=1; the next window at period 200 -> freq_out=5, freq_ovf=0.
REQ-037 sys_rst pulsed at cycle 600 of a window -> no meas_valid for that window; the next meas_valid arrives 1002 cycles after reset release.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared types and defaults for the ADC frequency meter: comparator state
// encoding, hysteresis thresholds and the peak tracker payload.
package dds_pkg;

    localparam int unsigned SAMPLE_W = 8;

    localparam logic [SAMPLE_W-1:0] DEF_HI_TH = 8'd160;
    localparam logic [SAMPLE_W-1:0] DEF_LO_TH = 8'd96;

    typedef enum logic [1:0] {
        CMP_INIT = 2'd0,
        CMP_LOW  = 2'd1,
        CMP_HIGH = 2'd2
    } cmp_state_e;

    typedef struct packed {
        logic [SAMPLE_W-1:0] pk_max;
        logic [SAMPLE_W-1:0] pk_min;
    } peak_t;

    // Empty tracker: the first sample of a window overwrites both fields.
    localparam peak_t PEAK_RESET = '{pk_max: 8'h00, pk_min: 8'hFF};

    function automatic peak_t peak_update(input peak_t p, input logic [SAMPLE_W-1:0] s);
        peak_t r;
        r = p;
        if (s > p.pk_max) r.pk_max = s;
        if (s < p.pk_min) r.pk_min = s;
        return r;
    endfunction

endpackage

// File: rtl/adc_hyst_cmp.sv
// Hysteresis comparator: tracks INIT/LOW/HIGH and strobes rise_c on the
// cycle a LOW-to-HIGH crossing is seen.
module adc_hyst_cmp
    import dds_pkg::*;
#(
    parameter logic [SAMPLE_W-1:0] HI_TH = DEF_HI_TH,
    parameter logic [SAMPLE_W-1:0] LO_TH = DEF_LO_TH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] sample,
    output logic                rise_c
);

    cmp_state_e state_q;
    cmp_state_e state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CMP_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rise_c  = 1'b0;
        if (en) begin
            case (state_q)
                CMP_INIT: begin
                    if (sample >= HI_TH) begin
                        state_d = CMP_HIGH;
                    end else if (sample <= LO_TH) begin
                        state_d = CMP_LOW;
                    end
                end
                CMP_LOW: begin
                    if (sample >= HI_TH) begin
                        state_d = CMP_HIGH;
                        rise_c  = 1'b1;
                    end
                end
                CMP_HIGH: begin
                    if (sample <= LO_TH) begin
                        state_d = CMP_LOW;
                    end
                end
                default: state_d = CMP_INIT;
            endcase
        end
    end

endmodule

// File: rtl/adc_freq_meter.sv
// Gate-window frequency and peak-to-peak meter for an 8-bit ADC stream.
// Counts hysteresis rise crossings per window and reports max-min.
module adc_freq_meter
    import dds_pkg::*;
#(
    parameter int unsigned         GATE_CYCLES = 50_000_000,
    parameter logic [SAMPLE_W-1:0] HI_TH       = DEF_HI_TH,
    parameter logic [SAMPLE_W-1:0] LO_TH       = DEF_LO_TH,
    parameter int unsigned         CNT_W       = 20
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    output logic                adc_clk,
    input  logic [SAMPLE_W-1:0] adc_data,
    output logic [CNT_W-1:0]    freq_out,
    output logic [SAMPLE_W-1:0] vpp_out,
    output logic                meas_valid,
    output logic                freq_ovf
);

    localparam int unsigned      GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [SAMPLE_W-1:0] sample_q;
    logic                run_q,      run_d;
    logic [GATE_W-1:0]   gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;
    logic                ovf_q,      ovf_d;
    peak_t               peak_q,     peak_d;
    logic [CNT_W-1:0]    freq_q,     freq_d;
    logic [SAMPLE_W-1:0] vpp_q,      vpp_d;
    logic                fovf_q,     fovf_d;
    logic                valid_q,    valid_d;

    logic                rise_c;
    logic                gate_end_c;
    logic [CNT_W-1:0]    edge_sum_c;
    logic                ovf_sum_c;
    peak_t               peak_sum_c;

    assign adc_clk = ~sys_clk;

    // Input stage; holds no state worth resetting.
    always_ff @(posedge sys_clk) begin
        sample_q <= adc_data;
    end

    adc_hyst_cmp #(
        .HI_TH (HI_TH),
        .LO_TH (LO_TH)
    ) u_cmp (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .en     (run_q),
        .sample (sample_q),
        .rise_c (rise_c)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            run_q      <= 1'b0;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
            peak_q     <= PEAK_RESET;
            freq_q     <= '0;
            vpp_q      <= '0;
            fovf_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            run_q      <= run_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            ovf_q      <= ovf_d;
            peak_q     <= peak_d;
            freq_q     <= freq_d;
            vpp_q      <= vpp_d;
            fovf_q     <= fovf_d;
            valid_q    <= valid_d;
        end
    end

    // run_q stays low for the cycle after reset, while sample_q still holds
    // data captured under reset.
    always_comb begin
        run_d      = 1'b1;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        ovf_d      = ovf_q;
        peak_d     = peak_q;
        freq_d     = freq_q;
        vpp_d      = vpp_q;
        fovf_d     = fovf_q;
        valid_d    = 1'b0;

        gate_end_c = run_q && (gate_cnt_q == GATE_LAST);

        edge_sum_c = edge_cnt_q;
        ovf_sum_c  = ovf_q;
        if (rise_c) begin
            if (edge_cnt_q == CNT_MAX) begin
                ovf_sum_c = 1'b1;
            end else begin
                edge_sum_c = edge_cnt_q + CNT_W'(1);
            end
        end
        peak_sum_c = peak_update(peak_q, sample_q);

        if (run_q) begin
            gate_cnt_d = gate_end_c ? '0 : gate_cnt_q + GATE_W'(1);
        end

        if (gate_end_c) begin
            freq_d     = edge_sum_c;
            fovf_d     = ovf_sum_c;
            vpp_d      = peak_sum_c.pk_max - peak_sum_c.pk_min;
            valid_d    = 1'b1;
            edge_cnt_d = '0;
            ovf_d      = 1'b0;
            peak_d     = PEAK_RESET;
        end else if (run_q) begin
            edge_cnt_d = edge_sum_c;
            ovf_d      = ovf_sum_c;
            peak_d     = peak_sum_c;
        end
    end

    assign freq_out   = freq_q;
    assign vpp_out    = vpp_q;
    assign freq_ovf   = fovf_q;
    assign meas_valid = valid_q;

endmodule

// File: tb/tb_adc_freq_meter.sv
// Self-checking bench for adc_freq_meter: a sample-level reference model
// queues expected window results, compared as meas_valid pulses arrive.
module tb_adc_freq_meter;
    import dds_pkg::*;

    localparam int G = 1000;

    logic        sys_clk;
    logic        sys_rst;
    logic [7:0]  adc_data;
    logic        adc_clk,    adc_clk3;
    logic [19:0] freq_out;
    logic [2:0]  freq_out3;
    logic [7:0]  vpp_out,    vpp_out3;
    logic        meas_valid, meas_valid3;
    logic        freq_ovf,   freq_ovf3;

    adc_freq_meter #(.GATE_CYCLES(G), .CNT_W(20)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .adc_clk    (adc_clk),
        .adc_data   (adc_data),
        .freq_out   (freq_out),
        .vpp_out    (vpp_out),
        .meas_valid (meas_valid),
        .freq_ovf   (freq_ovf)
    );

    adc_freq_meter #(.GATE_CYCLES(G), .CNT_W(3)) dut3 (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .adc_clk    (adc_clk3),
        .adc_data   (adc_data),
        .freq_out   (freq_out3),
        .vpp_out    (vpp_out3),
        .meas_valid (meas_valid3),
        .freq_ovf   (freq_ovf3)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [19:0] freq;
        logic [7:0]  vpp;
        logic        ovf;
        logic [2:0]  freq3;
        logic [7:0]  vpp3;
        logic        ovf3;
        logic        v3;
        logic [31:0] cyc;
    } obs_t;

    typedef struct packed {
        logic [31:0] rises;
        logic [7:0]  vpp;
    } exp_t;

    obs_t obs_q[$];
    exp_t exp_q[$];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cyc = 0;
    logic [31:0] rel_cyc = 0;

    // Reference model state (hysteresis 160/96, raw unsaturated rise count)
    int          m_state;
    int          m_idx;
    logic [31:0] m_rises;
    logic [7:0]  m_max, m_min;

    function automatic logic [7:0] sq(input int i, input int period);
        return ((i % period) < (period / 2)) ? 8'd0 : 8'd255;
    endfunction

    function automatic logic [41:0] pack_obs(input obs_t o);
        return {o.freq, o.vpp, o.ovf, o.freq3, o.vpp3, o.ovf3, o.v3};
    endfunction

    function automatic logic [41:0] exp_word(input exp_t e);
        logic [19:0] f20;
        logic [2:0]  f3;
        logic        o20, o3;
        o20 = (e.rises > 32'h000F_FFFF);
        o3  = (e.rises > 32'd7);
        f20 = o20 ? 20'hF_FFFF : e.rises[19:0];
        f3  = o3 ? 3'd7 : e.rises[2:0];
        return {f20, e.vpp, o20, f3, e.vpp, o3, 1'b1};
    endfunction

    // One clock: drive a sample, let the model consume it, record any result.
    task automatic tick(input logic [7:0] d);
        obs_t o;
        exp_t e;
        adc_data = d;
        @(posedge sys_clk);
        if (sys_rst) begin
            m_state = 0;
            m_idx   = 0;
            m_rises = 0;
            m_max   = 8'd0;
            m_min   = 8'd255;
            exp_q.delete();
        end else begin
            case (m_state)
                0: if (d >= 8'd160) m_state = 2; else if (d <= 8'd96) m_state = 1;
                1: if (d >= 8'd160) begin m_state = 2; m_rises = m_rises + 1; end
                default: if (d <= 8'd96) m_state = 1;
            endcase
            if (d > m_max) m_max = d;
            if (d < m_min) m_min = d;
            m_idx = m_idx + 1;
            if (m_idx == G) begin
                e.rises = m_rises;
                e.vpp   = m_max - m_min;
                exp_q.push_back(e);
                m_idx   = 0;
                m_rises = 0;
                m_max   = 8'd0;
                m_min   = 8'd255;
            end
        end
        #1;
        cyc = cyc + 1;
        if (meas_valid === 1'b1) begin
            o.freq  = freq_out;
            o.vpp   = vpp_out;
            o.ovf   = freq_ovf;
            o.freq3 = freq_out3;
            o.vpp3  = vpp_out3;
            o.ovf3  = freq_ovf3;
            o.v3    = meas_valid3;
            o.cyc   = cyc;
            obs_q.push_back(o);
        end
    endtask

    task automatic apply_reset();
        sys_rst = 1'b1;
        tick(8'd0);
        tick(8'd0);
        sys_rst = 1'b0;
        rel_cyc = cyc;
        obs_q.delete();
    endtask

    task automatic pop_pair(output obs_t o, output exp_t e, output bit ok);
        ok = (obs_q.size() > 0) && (exp_q.size() > 0);
        o  = '0;
        e  = '0;
        if (obs_q.size() > 0) o = obs_q.pop_front();
        if (exp_q.size() > 0) e = exp_q.pop_front();
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        tick(8'd200);
        tick(8'd200);
        checks++;
        if ({freq_out, vpp_out, freq_ovf, meas_valid} !== 30'd0) begin
            errors++;
            $display("FAIL reset_outputs: got freq=%0d vpp=%0d ovf=%0b valid=%0b expected all 0",
                     freq_out, vpp_out, freq_ovf, meas_valid);
        end
        checks++;
        if (dut.u_cmp.state_q !== CMP_INIT) begin
            errors++;
            $display("FAIL reset_state: got %0d expected INIT", dut.u_cmp.state_q);
        end
        checks++;
        if (adc_clk !== 1'b0 || adc_clk3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_adc_clk_hi: got %b/%b expected 0 while sys_clk high", adc_clk, adc_clk3);
        end
        @(negedge sys_clk);
        #1;
        checks++;
        if (adc_clk !== 1'b1) begin
            errors++;
            $display("FAIL reset_adc_clk_lo: got %b expected 1 while sys_clk low", adc_clk);
        end
        sys_rst = 1'b0;
        rel_cyc = cyc;
        obs_q.delete();
    endtask

    task automatic test_square();
        obs_t o; exp_t e; bit ok; int n; logic [31:0] prev;
        apply_reset();
        for (int i = 0; i < 2 * G + 5; i++) tick(sq(i, 100));
        n = obs_q.size();
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL square_count: got %0d pulses expected 2", n);
        end
        prev = 0;
        for (int k = 0; k < n; k++) begin
            pop_pair(o, e, ok);
            checks++;
            if (!ok || pack_obs(o) !== exp_word(e)) begin
                errors++;
                $display("FAIL square_sb[%0d]: got %h expected %h", k, pack_obs(o), exp_word(e));
            end
            checks++;
            if (o.freq !== 20'd10 || o.vpp !== 8'd255 || o.ovf !== 1'b0) begin
                errors++;
                $display("FAIL square_value[%0d]: got %0d/%0d/%0b expected 10/255/0", k, o.freq, o.vpp, o.ovf);
            end
            checks++;
            if (k == 0) begin
                // The cycle in which sys_rst drops counts as cycle 1.
                if (o.cyc - rel_cyc + 1 != 32'(G + 2)) begin
                    errors++;
                    $display("FAIL square_latency: got %0d expected %0d", o.cyc - rel_cyc + 1, G + 2);
                end
            end else if (o.cyc - prev != 32'(G)) begin
                errors++;
                $display("FAIL square_spacing: got %0d expected %0d", o.cyc - prev, G);
            end
            prev = o.cyc;
        end
    endtask

    task automatic test_constant();
        obs_t o; exp_t e; bit ok; int n;
        apply_reset();
        for (int i = 0; i < 2 * G + 5; i++) tick(8'd128);
        n = obs_q.size();
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL const_count: got %0d pulses expected 2", n);
        end
        for (int k = 0; k < n; k++) begin
            pop_pair(o, e, ok);
            checks++;
            if (!ok || pack_obs(o) !== exp_word(e) || o.freq !== 20'd0 || o.vpp !== 8'd0) begin
                errors++;
                $display("FAIL const_sb[%0d]: got %h expected %h", k, pack_obs(o), exp_word(e));
            end
        end
        checks++;
        if (dut.u_cmp.state_q !== CMP_INIT) begin
            errors++;
            $display("FAIL const_state: got %0d expected INIT", dut.u_cmp.state_q);
        end
    endtask

    task automatic test_noise_then_square();
        obs_t o; exp_t e; bit ok; int n; logic [19:0] want;
        apply_reset();
        for (int i = 0; i < 2 * G; i++) tick(8'(100 + (i % 51) + $urandom_range(0, 5)));
        for (int i = 0; i < 2 * G + 5; i++) tick(sq(i, 200));
        n = obs_q.size();
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL noise_count: got %0d pulses expected 4", n);
        end
        for (int k = 0; k < n; k++) begin
            pop_pair(o, e, ok);
            want = (k < 2) ? 20'd0 : 20'd5;
            checks++;
            if (!ok || pack_obs(o) !== exp_word(e)) begin
                errors++;
                $display("FAIL noise_sb[%0d]: got %h expected %h", k, pack_obs(o), exp_word(e));
            end
            checks++;
            if (o.freq !== want || o.freq3 !== want[2:0] || o.ovf3 !== 1'b0) begin
                errors++;
                $display("FAIL noise_freq[%0d]: got %0d/%0d expected %0d", k, o.freq, o.freq3, want);
            end
        end
    endtask

    task automatic test_boundary();
        obs_t o; exp_t e; bit ok; int n;
        int want_f[3] = '{1, 0, 1};
        int want_v[3] = '{255, 0, 0};
        apply_reset();
        for (int i = 0; i < 3 * G + 5; i++) tick((i == G - 1 || i >= 2 * G) ? 8'd255 : 8'd0);
        n = obs_q.size();
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL boundary_count: got %0d pulses expected 3", n);
        end
        for (int k = 0; k < n && k < 3; k++) begin
            pop_pair(o, e, ok);
            checks++;
            if (!ok || pack_obs(o) !== exp_word(e)) begin
                errors++;
                $display("FAIL boundary_sb[%0d]: got %h expected %h", k, pack_obs(o), exp_word(e));
            end
            checks++;
            if (o.freq !== 20'(want_f[k]) || o.vpp !== 8'(want_v[k])) begin
                errors++;
                $display("FAIL boundary_value[%0d]: got %0d/%0d expected %0d/%0d",
                         k, o.freq, o.vpp, want_f[k], want_v[k]);
            end
        end
    endtask

    task automatic test_overflow();
        obs_t o; exp_t e; bit ok; int n;
        apply_reset();
        for (int i = 0; i < G; i++) tick(sq(i, 4));
        for (int i = 0; i < G + 5; i++) tick(sq(i, 200));
        n = obs_q.size();
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL ovf_count: got %0d pulses expected 2", n);
        end
        for (int k = 0; k < n; k++) begin
            pop_pair(o, e, ok);
            checks++;
            if (!ok || pack_obs(o) !== exp_word(e)) begin
                errors++;
                $display("FAIL ovf_sb[%0d]: got %h expected %h", k, pack_obs(o), exp_word(e));
            end
            checks++;
            if (k == 0 && (o.freq3 !== 3'd7 || o.ovf3 !== 1'b1 || o.freq !== 20'd250 || o.ovf !== 1'b0)) begin
                errors++;
                $display("FAIL ovf_sat: got w3=%0d/%0b w20=%0d/%0b expected 7/1 250/0", o.freq3, o.ovf3, o.freq, o.ovf);
            end else if (k == 1 && (o.freq3 !== 3'd5 || o.ovf3 !== 1'b0)) begin
                errors++;
                $display("FAIL ovf_recover: got %0d/%0b expected 5/0", o.freq3, o.ovf3);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o; exp_t e; bit ok; int n;
        apply_reset();
        for (int i = 0; i < 600; i++) tick(sq(i, 100));
        sys_rst = 1'b1;
        tick(8'd0);
        sys_rst = 1'b0;
        rel_cyc = cyc;
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL midrst_early: got %0d pulses expected 0", obs_q.size());
        end
        obs_q.delete();
        for (int i = 0; i < G + 5; i++) tick(sq(i, 100));
        n = obs_q.size();
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL midrst_count: got %0d pulses expected 1", n);
        end
        if (n > 0) begin
            pop_pair(o, e, ok);
            checks++;
            if (!ok || pack_obs(o) !== exp_word(e) || o.freq !== 20'd10) begin
                errors++;
                $display("FAIL midrst_sb: got %h expected %h", pack_obs(o), exp_word(e));
            end
            checks++;
            if (o.cyc - rel_cyc + 1 != 32'(G + 2)) begin
                errors++;
                $display("FAIL midrst_latency: got %0d expected %0d", o.cyc - rel_cyc + 1, G + 2);
            end
        end
    endtask

    initial begin
        sys_rst  = 1'b1;
        adc_data = 8'd0;
        test_reset();
        test_square();
        test_constant();
        test_noise_then_square();
        test_boundary();
        test_overflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench still running after 5 ms, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
